// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: line levels and receiver states.
package serial_pkg;

  // Line levels common to transmitter and receiver.
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // Receiver states, explicitly encoded so the encoding stays stable.
  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_IDLE = 3'd5
  } rx_state_t;

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: tick marks mid-bit (half=1) or full-bit (half=0) sample points.
module serial_bit_timer
  import serial_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic half,
  output logic tick
);

  localparam int CW     = $clog2(BIT_CYCLES + 1);
  localparam int HALF_N = BIT_CYCLES / 2;
  localparam logic [CW-1:0] FULL_T = CW'(BIT_CYCLES - 1);
  // A zero-length half period never reaches the timer; the FSM skips START then.
  localparam logic [CW-1:0] HALF_T = (HALF_N > 0) ? CW'(HALF_N - 1) : '0;

  logic [CW-1:0] cnt;
  logic [CW-1:0] term;

  assign term = half ? HALF_T : FULL_T;
  assign tick = (cnt == term);

  // Count up from zero after each restart, holding at the terminal value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (cnt != term) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_rx.sv
// Serial frame receiver: start / data (LSB first) / optional parity / stop,
// delivered on a valid/ready handshake with one-cycle error pulses.
//
// state        | meaning
// -------------+---------------------------------------------------------
// RX_IDLE      | waiting for a falling edge after the line was seen high
// RX_START     | confirming the start bit at mid-bit
// RX_DATA      | sampling WIDTH data bits, LSB first
// RX_PARITY    | sampling the parity bit and recording a mismatch
// RX_STOP      | sampling the stop bit and resolving the frame
// RX_WAIT_IDLE | after a framing error, waiting for the line to go high
module serial_rx
  import serial_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int BIT_CYCLES = 1,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  // With one cycle per bit the detection edge already is the start sample.
  localparam bit SKIP_START = ((BIT_CYCLES / 2) == 0);
  localparam bit HAS_PARITY = (PARITY_EN != 0);
  localparam logic ODD_BIT  = (PARITY_ODD != 0);

  rx_state_t        state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic             line_high;
  logic             par_mis;
  logic             tick;
  logic             restart;

  // The timer is held clear while idle, so every busy state starts from zero.
  assign restart = tick || (state == RX_IDLE) || (state == RX_WAIT_IDLE);

  assign busy = (state == RX_START) || (state == RX_DATA) ||
                (state == RX_PARITY) || (state == RX_STOP);

  serial_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .half   (state == RX_START),
    .tick   (tick)
  );

  // Frame FSM, shift register and output handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RX_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      line_high  <= 1'b0;
      par_mis    <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      // Consumption; a word loading on this same edge overrides it below.
      if (valid && ready) valid <= 1'b0;

      case (state)
        RX_IDLE: begin
          if (rx_in == LINE_IDLE) begin
            line_high <= 1'b1;
          end else if (line_high) begin
            bit_cnt <= '0;
            par_mis <= 1'b0;
            state   <= SKIP_START ? RX_DATA : RX_START;
          end
        end
        RX_START: begin
          if (tick) state <= (rx_in == START_LVL) ? RX_DATA : RX_IDLE;
        end
        RX_DATA: begin
          if (tick) begin
            shreg <= {rx_in, shreg[WIDTH-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= HAS_PARITY ? RX_PARITY : RX_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        RX_PARITY: begin
          if (tick) begin
            par_mis <= ((^shreg) ^ ODD_BIT) != rx_in;
            state   <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (rx_in != STOP_LVL) begin
              // A low stop bit means the line is not idle; wait for it to rise.
              frame_err <= 1'b1;
              line_high <= 1'b0;
              state     <= RX_WAIT_IDLE;
            end else begin
              state <= RX_IDLE;
              if (par_mis) begin
                parity_err <= 1'b1;
              end else if (!valid || ready) begin
                data_out <= shreg;
                valid    <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end
        end
        RX_WAIT_IDLE: begin
          if (rx_in == LINE_IDLE) begin
            line_high <= 1'b1;
            state     <= RX_IDLE;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Scoreboard bench for serial_rx: stimulus pushes expected events, a monitor
// pops them as the receiver delivers words or pulses error flags.
module tb_serial_rx;

  localparam logic [1:0] EV_WORD = 2'd0;
  localparam logic [1:0] EV_PERR = 2'd1;
  localparam logic [1:0] EV_FERR = 2'd2;
  localparam logic [1:0] EV_OVR  = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_in = 1'b1;
  logic       ready = 1'b1;
  logic [3:0] data_out;
  logic       valid, busy, parity_err, frame_err, overrun;

  logic       rx2 = 1'b1;
  logic       ready2 = 1'b1;
  logic [3:0] data2;
  logic       valid2, busy2, perr2, ferr2, ovr2;

  int pass_cnt = 0;
  int total_cnt = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  serial_rx #(.WIDTH(4), .BIT_CYCLES(1), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .rx_in(rx_in), .data_out(data_out), .valid(valid),
    .ready(ready), .busy(busy), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun)
  );

  serial_rx #(.WIDTH(4), .BIT_CYCLES(4), .PARITY_EN(1), .PARITY_ODD(0)) dut4 (
    .clk(clk), .reset(reset), .rx_in(rx2), .data_out(data2), .valid(valid2),
    .ready(ready2), .busy(busy2), .parity_err(perr2), .frame_err(ferr2),
    .overrun(ovr2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic sb_check(input logic [1:0] kind, input logic [3:0] d);
    ev_t e;
    total_cnt++;
    if (exp_q.size() == 0) begin
      $display("FAIL sb_unexpected: got kind %0d data %0h expected no event", kind, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.data == d) pass_cnt++;
      else $display("FAIL sb_event: got kind %0d data %0h expected kind %0d data %0h",
                    kind, d, e.kind, e.data);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [3:0] d);
    ev_t e;
    e.kind = kind;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // frame bit 0 is the start bit; data LSB first, then parity, then stop
  function automatic logic [6:0] mk_frame(input logic [3:0] d, input logic par, input logic stop);
    return {stop, par, d, 1'b0};
  endfunction

  // Called just after a rising edge; each bit is held for one clock.
  task automatic send_bits(input logic [6:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_in = bits[i];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every pulse or handshake seen before an edge is one event.
  always @(negedge clk) begin
    if (!reset) begin
      if (parity_err) sb_check(EV_PERR, 4'h0);
      if (frame_err)  sb_check(EV_FERR, 4'h0);
      if (overrun)    sb_check(EV_OVR, 4'h0);
      if (valid && ready) sb_check(EV_WORD, data_out);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    logic [6:0] f;
    logic [3:0] cap;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", data_out, 4'h0);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pulses", {parity_err, frame_err, overrun}, 3'b000);
    reset = 1'b0;
    idle(2);

    // parity bit wrong: word dropped, data_out stays 0
    push(EV_PERR, 4'h0);
    send_bits(mk_frame(4'h6, 1'b1, 1'b1), 7);
    check("perr_pulse", parity_err, 1'b1);
    check("perr_valid", valid, 1'b0);
    check("perr_data", data_out, 4'h0);
    idle(1);
    check("perr_one_cycle", parity_err, 1'b0);
    idle(1);

    // good frame 6, result present right after the stop-sample edge
    push(EV_WORD, 4'h6);
    send_bits(mk_frame(4'h6, 1'b0, 1'b1), 7);
    check("t1_valid", valid, 1'b1);
    check("t1_data", data_out, 4'h6);
    check("t1_busy", busy, 1'b0);
    idle(2);

    // stop bit low, line held low: one frame error and no retrigger
    push(EV_FERR, 4'h0);
    send_bits(mk_frame(4'h6, 1'b0, 1'b0), 7);
    check("ferr_pulse", frame_err, 1'b1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      rx_in = 1'b0;
      @(posedge clk);
      #1;
      if (busy !== 1'b0) bad++;
    end
    check("ferr_no_retrigger", bad, 0);
    idle(2);
    push(EV_WORD, 4'h5);
    send_bits(mk_frame(4'h5, 1'b0, 1'b1), 7);
    check("t3_data", data_out, 4'h5);
    idle(2);

    // overrun with ready low: old word kept
    ready = 1'b0;
    push(EV_OVR, 4'h0);
    push(EV_WORD, 4'h6);
    send_bits(mk_frame(4'h6, 1'b0, 1'b1), 7);
    check("ovr_first_valid", valid, 1'b1);
    send_bits(mk_frame(4'h9, 1'b0, 1'b1), 7);
    check("ovr_pulse", overrun, 1'b1);
    check("ovr_data_kept", data_out, 4'h6);
    idle(2);
    check("ovr_valid_held", valid, 1'b1);
    ready = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_valid_dropped", valid, 1'b0);
    idle(2);

    // back-to-back frames, no idle gap
    push(EV_WORD, 4'h6);
    push(EV_WORD, 4'hA);
    send_bits(mk_frame(4'h6, 1'b0, 1'b1), 7);
    send_bits(mk_frame(4'hA, 1'b0, 1'b1), 7);
    check("b2b_data", data_out, 4'hA);
    check("b2b_no_ovr", overrun, 1'b0);
    idle(2);

    // reset in mid-frame, then a clean frame
    send_bits(mk_frame(4'h3, 1'b0, 1'b1), 3);
    check("mid_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_data", data_out, 4'h0);
    check("mid_rst_outs", {valid, busy, parity_err, frame_err, overrun}, 5'b00000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);
    push(EV_WORD, 4'h3);
    send_bits(mk_frame(4'h3, 1'b0, 1'b1), 7);
    check("t6_data", data_out, 4'h3);
    idle(3);

    // BIT_CYCLES=4: start detected on edge 0, stop sampled on edge 26
    f = mk_frame(4'h6, 1'b0, 1'b1);
    bad = 0;
    cap = 4'h0;
    for (int c = 0; c < 32; c++) begin
      rx2 = (c < 28) ? f[c/4] : 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (valid2 !== (c == 26)) bad++;
      if (busy2 !== (c < 26)) bad++;
      if ({perr2, ferr2, ovr2} !== 3'b000) bad++;
      if (c == 26) cap = data2;
    end
    check("bc4_timing", bad, 0);
    check("bc4_data", cap, 4'h6);

    idle(3);
    check("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
